usbf_dma_arb: RTL
=================

Name: usbf_dma_arb

Overview:
- Round-robin DMA request arbiter between the per-endpoint register files and the single external DMA bus master.
- Collects `dma_req` from up to NUM_EP endpoint register files and grants one endpoint at a time.
- Forwards the granted endpoint number to the master as a word-request handshake.
- Returns a one-cycle `dma_ack` pulse to the granted endpoint for every word the master completes.
- Bounds each grant to BURST_MAX words so that no endpoint can starve the others.

Parameters:
- NUM_EP, 16, number of endpoint request/ack pairs (2..16).
- EP_W, 4, width of the endpoint index; must satisfy 2**EP_W >= NUM_EP.
- BURST_MAX, 8, maximum words per grant before re-arbitration (1..255).
- SETTLE_CYC, 2, idle cycles after each ack before the granted request is re-sampled (1..15).

Ports:
- clk  in  1  block clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- arb_en  in  1  global enable; low means no new grants are issued.
- ep_dma_req  in  NUM_EP  level request from each endpoint register file.
- ep_dma_ack  out  NUM_EP  one-cycle per-word acknowledge to each endpoint.
- mst_req  out  1  word request to the DMA master.
- mst_ep  out  EP_W  endpoint index of the current request.
- mst_ack  in  1  master completed one word; sampled only while mst_req=1.
- arb_busy  out  1  high whenever the state is not IDLE.
- burst_cnt  out  8  words completed in the current grant.

Behaviour:
- Reset values:
  - state=IDLE, grant=0, last=NUM_EP-1 (so EP0 has first priority).
  - burst_cnt=0, settle counter=0, ep_dma_ack=0.
  - mst_req=0, mst_ep=0, arb_busy=0.
  - Reset asserted mid-transfer aborts at once: no ack pulse is issued for an in-flight word.
- States: IDLE, XFER, SETTLE.
- IDLE:
  - If arb_en=1 and |ep_dma_req, then grant <= first requesting index searching upward from (last+1) mod NUM_EP with wrap, and state <= XFER.
  - Latency: a request visible at edge n gives mst_req=1 in cycle n+1.
- XFER:
  - mst_req=1 and mst_ep=grant. These are decoded from registered state and grant, with no combinational path from ep_dma_req.
  - mst_ack=1:
    - ep_dma_ack[grant] <= 1 for exactly one cycle.
    - burst_cnt <= burst_cnt+1.
    - settle <= SETTLE_CYC-1.
    - state <= SETTLE.
  - mst_ack=0 and ep_dma_req[grant]=0 (endpoint withdrew, e.g. DMA disabled): last <= grant, burst_cnt <= 0, state <= IDLE. No ack is issued.
  - mst_ack=1 in the same cycle the request drops: the ack wins and the word counts.
  - arb_en falling during XFER does not abort; the outstanding word completes.
- SETTLE:
  - mst_req=0.
  - settle decrements each cycle.
  - When settle=0:
    - If arb_en & ep_dma_req[grant] & (burst_cnt != BURST_MAX), state <= XFER. The grant is kept.
    - Otherwise last <= grant, burst_cnt <= 0, state <= IDLE.
  - SETTLE_CYC covers the endpoint's registered request deassert after ack, so a stale request is never taken as new.
- ep_dma_ack is one-hot or zero at all times; it never pulses for a non-granted index.
- mst_ack is ignored while state != XFER.
- Indices >= NUM_EP are never granted. ep_dma_req bits above NUM_EP do not exist.
- burst_cnt is 8 bits wide and never exceeds BURST_MAX.
- arb_busy = (state != IDLE).
- Minimum per-word period is 1 + SETTLE_CYC + (master latency) cycles.

Test Plan:
- Single requester: assert ep_dma_req[3] after reset; master acks the cycle after mst_req.
  - Required: mst_ep=3.
  - Required: ep_dma_ack[3] pulses once per word, with 2 cycles mst_req=0 between words.
  - Required: after 8 words mst_req drops, the arbiter returns to IDLE, then re-grants EP3.
- Round-robin fairness: EP0, EP5 and EP15 request continuously; master always acks.
  - Required grant order: 0, 5, 15, 0, 5, …
  - Required: each grant lasts exactly 8 words (burst_cnt 1..8).
- Wrap-around: last=15, only EP2 and EP14 request.
  - Required: EP2 is granted first, then EP14.
- Request withdrawal: EP1 drops its request while in XFER with no ack.
  - Required: IDLE next cycle, no ep_dma_ack pulse, burst_cnt=0.
  - Repeat with mst_ack coincident with the drop: required is one ack pulse, then IDLE after SETTLE.
- Enable and reset:
  - arb_en=0 with requests pending: required is no mst_req.
  - arb_en dropped mid-XFER: the word completes and acks, then IDLE.
  - rst pulsed in XFER: all outputs 0 next cycle, and EP0 wins the next arbitration.

Source files
------------

// File: rtl/usbf_dma_arb_if.sv
// usbf_dma_arb_if: endpoint request/ack and DMA master word handshake bundle
interface usbf_dma_arb_if #(
   parameter int NUM_EP = 16,
   parameter int EP_W = 4
);
   logic arb_en;
   logic [NUM_EP-1:0] ep_dma_req;
   logic [NUM_EP-1:0] ep_dma_ack;
   logic mst_req;
   logic [EP_W-1:0] mst_ep;
   logic mst_ack;
   logic arb_busy;
   logic [7:0] burst_cnt;
   modport master (
      input arb_en, ep_dma_req, mst_ack,
      output ep_dma_ack, mst_req, mst_ep, arb_busy, burst_cnt
   );
   modport slave (
      output arb_en, ep_dma_req, mst_ack,
      input ep_dma_ack, mst_req, mst_ep, arb_busy, burst_cnt
   );
endinterface

// File: rtl/usbf_dma_arb.sv
// usbf_dma_arb: round-robin arbiter granting endpoint DMA word requests to one master
module usbf_dma_arb #(
   parameter int NUM_EP = 16,
   parameter int EP_W = 4,
   parameter int BURST_MAX = 8,
   parameter int SETTLE_CYC = 2
) (
   input logic clk,
   input logic rst,
   usbf_dma_arb_if.master bus
);
   typedef enum logic [1:0] {IDLE, XFER, SETTLE} state_t;
   state_t state, state_n;
   logic [EP_W-1:0] grant, grant_n, last, last_n, pick, idx;
   logic [7:0] burst, burst_n;
   logic [3:0] settle, settle_n;
   logic [NUM_EP-1:0] ack, ack_n;
   // descending scan so the nearest requester above last wins
   always_comb begin
      pick = last;
      idx = last;
      for (int i = NUM_EP; i >= 1; i--) begin
         idx = EP_W'((int'(last) + i) % NUM_EP);
         if (bus.ep_dma_req[idx]) pick = idx;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         grant <= '0;
         last <= EP_W'(NUM_EP - 1);
         burst <= '0;
         settle <= '0;
         ack <= '0;
      end else begin
         state <= state_n;
         grant <= grant_n;
         last <= last_n;
         burst <= burst_n;
         settle <= settle_n;
         ack <= ack_n;
      end
   end
   always_comb begin
      state_n = state;
      grant_n = grant;
      last_n = last;
      burst_n = burst;
      settle_n = settle;
      ack_n = '0;
      case (state)
         IDLE:
            if (bus.arb_en && |bus.ep_dma_req) begin
               grant_n = pick;
               state_n = XFER;
            end
         XFER:
            if (bus.mst_ack) begin
               ack_n[grant] = 1'b1;
               burst_n = burst + 8'd1;
               settle_n = 4'(SETTLE_CYC - 1);
               state_n = SETTLE;
            end else if (!bus.ep_dma_req[grant]) begin
               last_n = grant;
               burst_n = '0;
               state_n = IDLE;
            end
         SETTLE:
            if (settle != 4'd0) settle_n = settle - 4'd1;
            else if (bus.arb_en && bus.ep_dma_req[grant] && burst != 8'(BURST_MAX)) state_n = XFER;
            else begin
               last_n = grant;
               burst_n = '0;
               state_n = IDLE;
            end
         default: state_n = IDLE;
      endcase
   end
   always_comb begin
      bus.mst_req = state == XFER;
      bus.mst_ep = grant;
      bus.arb_busy = state != IDLE;
      bus.burst_cnt = burst;
      bus.ep_dma_ack = ack;
   end
endmodule
